// File: rtl/gray_cdc_pkg.sv
// Shared Gray-code helpers for the CDC counter path (source counter, receive
// stage, FIFO pointer logic). The functions work on a MAX_W-bit container:
// callers zero-extend a narrower count in and truncate the result back out.
// Zero upper bits do not change a Gray<->binary conversion or a popcount,
// so one body serves every width up to MAX_W.
package gray_cdc_pkg;

  localparam int MAX_W           = 32;
  localparam int POP_W           = $clog2(MAX_W + 1);
  localparam int SYNC_STAGES_MIN = 2;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: adjacent-bit XOR.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits; used to detect multi-bit Gray steps.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-bit flop synchronizer chain with synchronous reset. Kept as its own
// module so CDC constraints (false path / max-delay on the first stage) can
// target this instance. Depth is clamped to the minimum safe value.
module sync_chain
  import gray_cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int DEPTH = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // Shift the asynchronous input through DEPTH flops every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/gray_sync_rx.sv
// Receive side of a Gray-coded cross-domain count: synchronize, decode to
// binary, report the advance since the last accepted sample and (optionally)
// flag illegal multi-bit Gray steps.
// Optional feature macro: GRAY_SYNC_ERR_CHECK_EN enables the sticky err
// check; without it err is tied low and err_clr is ignored.
module gray_sync_rx
  import gray_cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] delta,
  output logic             inc_pulse,
  output logic             err
);

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] delta_reg;
  logic             inc_reg;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk  (clk),
    .rst  (rst),
    .din  (gray_in),
    .dout (gray_sync)
  );

  assign bin_next = WIDTH'(gray2bin(MAX_W'(gray_sync)));

  // Accept a decoded sample when enabled; delta wraps modulo 2^WIDTH so a
  // long en=0 gap still reports the full advance at the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      delta_reg <= '0;
      inc_reg   <= 1'b0;
    end else if (en) begin
      acc_reg   <= bin_next;
      delta_reg <= bin_next - acc_reg;
      inc_reg   <= (bin_next != acc_reg);
    end else begin
      inc_reg   <= 1'b0;
    end
  end

  assign bin_out   = acc_reg;
  assign delta     = delta_reg;
  assign inc_pulse = inc_reg;

`ifdef GRAY_SYNC_ERR_CHECK_EN
  logic [WIDTH-1:0] prev_reg;
  logic             err_reg;
  logic             viol_next;

  assign viol_next = popcount(MAX_W'(gray_sync ^ prev_reg)) > POP_W'(1);

  // Compare consecutive synchronized values; a new violation beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      prev_reg <= gray_sync;
      err_reg  <= viol_next | (err_reg & ~err_clr);
    end
  end

  assign err = err_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed bench for gray_sync_rx (WIDTH=8, SYNC_STAGES=2). Expected err
// values follow whether GRAY_SYNC_ERR_CHECK_EN is defined for the build.
module tb_gray_sync_rx;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;

`ifdef GRAY_SYNC_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] gray_in;
  logic             en;
  logic             err_clr;
  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] delta;
  logic             inc_pulse;
  logic             err;

  int checks;
  int errors;

  gray_sync_rx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .en        (en),
    .err_clr   (err_clr),
    .gray_sync (gray_sync),
    .bin_out   (bin_out),
    .delta     (delta),
    .inc_pulse (inc_pulse),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side Gray encoder for stimulus.
  function automatic logic [WIDTH-1:0] to_gray(input int b);
    logic [WIDTH-1:0] v;
    v = WIDTH'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock and settle past the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    gray_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gray_sync"}, 32'(gray_sync), 32'h0);
    chk({tag, "_bin_out"},   32'(bin_out),   32'h0);
    chk({tag, "_delta"},     32'(delta),     32'h0);
    chk({tag, "_inc"},       32'(inc_pulse), 32'h0);
    chk({tag, "_err"},       32'(err),       32'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    en      = 1'b0;
    err_clr = 1'b0;
    gray_in = 8'h5A;

    // Reset with a non-zero input held: everything stays 0.
    tick();
    tick();
    chk_all_zero("rst");

    // Release: 0x5A decodes to 0x6C after SYNC_STAGES+1 edges.
    rst = 1'b0;
    en  = 1'b1;
    tick();
    tick();
    chk("rel_gray_sync", 32'(gray_sync), 32'h5A);
    chk("rel_bin_early", 32'(bin_out),   32'h00);
    tick();
    chk("rel_bin_out",   32'(bin_out),   32'h6C);
    chk("rel_delta",     32'(delta),     32'h6C);
    chk("rel_inc",       32'(inc_pulse), 32'h1);
    chk("rel_err",       32'(err),       32'(ERR_EN));  // 0 -> 0x5A is 4 bits
    tick();
    chk("rel_hold_inc",   32'(inc_pulse), 32'h0);
    chk("rel_hold_delta", 32'(delta),     32'h0);
    chk("rel_err_sticky", 32'(err),       32'(ERR_EN));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("rel_err_clr", 32'(err), 32'h0);

    // Counting stream 0..0x101 (mod 256): covers steady counting and wrap.
    do_reset();
    en = 1'b1;
    for (int k = 0; k <= 259; k++) begin
      if (k <= 257) gray_in = to_gray(k);
      tick();
      if (k >= 3) begin
        chk($sformatf("cnt_bin_%0d", k - 2), 32'(bin_out), 32'((k - 2) & 8'hFF));
        chk($sformatf("cnt_delta_%0d", k - 2), 32'(delta), 32'h1);
        chk($sformatf("cnt_inc_%0d", k - 2), 32'(inc_pulse), 32'h1);
      end
    end
    chk("cnt_err", 32'(err), 32'h0);

    // Enable gating: source advances 1 -> 8 while en=0.
    en = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      gray_in = to_gray(k);
      tick();
    end
    tick();
    tick();
    tick();
    chk("gate_gray_sync", 32'(gray_sync), 32'h0C);
    chk("gate_bin_held",  32'(bin_out),   32'h01);
    chk("gate_inc_low",   32'(inc_pulse), 32'h0);
    en = 1'b1;
    tick();
    chk("gate_bin_jump", 32'(bin_out),   32'h08);
    chk("gate_delta",    32'(delta),     32'h07);
    chk("gate_inc",      32'(inc_pulse), 32'h1);
    tick();
    chk("gate_inc_once", 32'(inc_pulse), 32'h0);
    chk("gate_err",      32'(err),       32'h0);

    // Illegal step 0x00 -> 0x03.
    do_reset();
    gray_in = 8'h03;
    tick();
    tick();
    chk("ill_gray_sync", 32'(gray_sync), 32'h03);
    chk("ill_err_pre",   32'(err),       32'h0);
    tick();
    chk("ill_err_set",   32'(err),       32'(ERR_EN));
    tick();
    tick();
    chk("ill_err_stays", 32'(err),       32'(ERR_EN));
    // New violation 0x03 -> 0x0C arrives in the same cycle as err_clr.
    gray_in = 8'h0C;
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_set_wins", 32'(err), 32'(ERR_EN));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_clr", 32'(err), 32'h0);

    // Reset mid-stream at bin_out=0x40 with err set.
    do_reset();
    en      = 1'b1;
    gray_in = to_gray(8'h40);
    tick();
    tick();
    tick();
    chk("mid_bin_pre", 32'(bin_out), 32'h40);
    chk("mid_err_pre", 32'(err),     32'(ERR_EN));
    gray_in = to_gray(8'h41);
    rst     = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    tick();
    tick();
    chk("mid_bin_early", 32'(bin_out),   32'h00);
    tick();
    chk("mid_bin_out",   32'(bin_out),   32'h41);
    chk("mid_delta",     32'(delta),     32'h41);
    chk("mid_inc",       32'(inc_pulse), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
